fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, one-cycle-latency memory
// tracking, and a 2-entry {pc, instr} buffer feeding decode, with redirect flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err
);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];

    logic        pop, push, issue;
    logic [2:0]  credit;

    assign imem_addr    = pc_q;
    assign misalign_err = misalign_q;
    assign out_valid    = (count_q != 2'd0) & ~redirect_valid & ~rst;
    assign out_pc       = (count_q != 2'd0) ? fifo_pc_q[rd_ptr_q]    : 32'h0;
    assign out_instr    = (count_q != 2'd0) ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign pop          = out_valid & out_ready;

    // Buffered plus outstanding entries must stay below capacity so the
    // returning word always has a slot.
    assign credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue  = ~rst & ~redirect_valid & (credit < 3'd2);
    assign push   = ~rst & ~redirect_valid & inflight_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        misalign_d    = redirect_valid & (redirect_pc[1:0] != 2'b00);
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            misalign_q    <= misalign_d;
        end
    end

    // Payload storage needs no reset; count qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a registered memory model feeds the DUT and
// every accepted output is compared against the expected sequential pc stream.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;
    int npop  = 0;
    logic [63:0] exp_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: memf = 32'h0000_0013;
            32'h0000_0004: memf = 32'h0010_0093;
            default:       memf = a ^ 32'h5A5A_0013;
        endcase
    endfunction

    // Read data appears the cycle after the address.
    always @(posedge clk) imem_data <= memf(imem_addr);

    always @(negedge clk) begin
        total++;
        if (out_valid && (rst || redirect_valid)) begin
            bad++;
            $display("FAIL valid_during_flush got=%b exp=0", out_valid);
        end
        if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pop got pc=%h instr=%h exp=none", out_pc, out_instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({out_pc, out_instr} !== e) begin
                    bad++;
                    $display("FAIL pop_order got=%h_%h exp=%h_%h", out_pc, out_instr, e[63:32], e[31:0]);
                end
                npop++;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic start_stream(input logic [31:0] a);
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back({a + 32'(4 * i), memf(a + 32'(4 * i))});
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt(); mid();
            total++;
            if (out_valid !== 1'b0 || misalign_err !== 1'b0 || imem_addr !== 32'h0 ||
                out_pc !== 32'h0 || out_instr !== 32'h0) begin
                bad++;
                $display("FAIL reset_state got v=%b m=%b a=%h pc=%h i=%h exp=0", out_valid,
                         misalign_err, imem_addr, out_pc, out_instr);
            end
        end
    endtask

    task automatic test_startup();
        int n0;
        nxt();
        rst = 1'b0; start_stream(32'h0); n0 = npop;
        mid(); total++;
        if (imem_addr !== 32'h0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL startup_c0 got a=%h v=%b exp a=0 v=0", imem_addr, out_valid);
        end
        nxt(); mid(); total++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h4) begin
            bad++; $display("FAIL startup_c1 got v=%b a=%h exp v=0 a=4", out_valid, imem_addr);
        end
        nxt(); mid(); total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0000_0013) begin
            bad++; $display("FAIL startup_c2 got v=%b pc=%h i=%h exp 1/0/13", out_valid, out_pc, out_instr);
        end
        nxt(); mid(); total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h0010_0093) begin
            bad++; $display("FAIL startup_c3 got v=%b pc=%h i=%h exp 1/4/100093", out_valid, out_pc, out_instr);
        end
        for (int i = 0; i < 4; i++) begin nxt(); mid(); end
        nxt(); total++;
        if (npop - n0 !== 6) begin
            bad++; $display("FAIL startup_rate got=%0d exp=6", npop - n0);
        end
    endtask

    task automatic test_backpressure();
        int n0;
        rst = 1'b1; out_ready = 1'b0;
        nxt();
        rst = 1'b0; start_stream(32'h0);
        for (int c = 0; c < 7; c++) begin
            mid();
            if (c >= 3) begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0000_0013 ||
                    imem_addr !== 32'h8) begin
                    bad++;
                    $display("FAIL bp_hold got v=%b pc=%h i=%h a=%h exp 1/0/13/8", out_valid,
                             out_pc, out_instr, imem_addr);
                end
            end
            nxt();
        end
        out_ready = 1'b1; n0 = npop;
        for (int c = 0; c < 3; c++) begin
            mid(); total++;
            if (out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_drain_gap got v=%b exp=1", out_valid);
            end
            nxt();
        end
        total++;
        if (npop - n0 !== 3) begin
            bad++; $display("FAIL bp_drain_count got=%0d exp=3", npop - n0);
        end
    endtask

    task automatic redirect_checks(input logic [31:0] tgt, input logic [31:0] aligned,
                                   input logic exp_mis);
        redirect_valid = 1'b1; redirect_pc = tgt; out_ready = 1'b1;
        start_stream(aligned);
        mid(); total++;
        if (out_valid !== 1'b0 || misalign_err !== 1'b0) begin
            bad++; $display("FAIL redir_r got v=%b m=%b exp 0/0", out_valid, misalign_err);
        end
        nxt(); redirect_valid = 1'b0;
        mid(); total++;
        if (out_valid !== 1'b0 || imem_addr !== aligned || out_pc !== 32'h0 ||
            out_instr !== 32'h0 || misalign_err !== exp_mis) begin
            bad++;
            $display("FAIL redir_r1 got v=%b a=%h pc=%h i=%h m=%b exp 0/%h/0/0/%b", out_valid,
                     imem_addr, out_pc, out_instr, misalign_err, aligned, exp_mis);
        end
        nxt(); mid(); total++;
        if (out_valid !== 1'b0 || misalign_err !== 1'b0 || imem_addr !== aligned + 32'd4) begin
            bad++;
            $display("FAIL redir_r2 got v=%b m=%b a=%h exp 0/0/%h", out_valid, misalign_err,
                     imem_addr, aligned + 32'd4);
        end
        nxt(); mid(); total++;
        if (out_valid !== 1'b1 || out_pc !== aligned || out_instr !== memf(aligned)) begin
            bad++;
            $display("FAIL redir_r3 got v=%b pc=%h i=%h exp 1/%h/%h", out_valid, out_pc,
                     out_instr, aligned, memf(aligned));
        end
        nxt();
    endtask

    task automatic test_redirect();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) nxt();
        out_ready = 1'b0;
        redirect_checks(32'h0000_0100, 32'h0000_0100, 1'b0);
        for (int i = 0; i < 3; i++) nxt();
    endtask

    task automatic test_misalign();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) nxt();
        redirect_checks(32'h0000_0102, 32'h0000_0100, 1'b1);
        for (int i = 0; i < 3; i++) nxt();
    endtask

    task automatic test_wrap();
        redirect_checks(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        mid(); total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== memf(32'h0)) begin
            bad++; $display("FAIL wrap_next got v=%b pc=%h i=%h exp 1/0/13", out_valid, out_pc, out_instr);
        end
        nxt();
    endtask

    task automatic test_back_to_back();
        start_stream(32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        nxt(); redirect_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            nxt();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mid(); total++;
            if (out_valid !== 1'b1) begin
                bad++; $display("FAIL b2b_gap got v=%b exp=1", out_valid);
            end
            nxt();
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) nxt();
        rst = 1'b1;
        mid(); total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_s got v=%b exp=0", out_valid);
        end
        nxt();
        rst = 1'b0; out_ready = 1'b1; start_stream(32'h0);
        mid(); total++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0) begin
            bad++; $display("FAIL rstmid_s1 got v=%b a=%h pc=%h exp 0/0/0", out_valid, imem_addr, out_pc);
        end
        nxt(); nxt(); mid(); total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0000_0013) begin
            bad++; $display("FAIL rstmid_s3 got v=%b pc=%h i=%h exp 1/0/13", out_valid, out_pc, out_instr);
        end
        for (int i = 0; i < 4; i++) nxt();
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
